maxnum_step_counter: RTL and testbench



---
 rtl/maxnum_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 45 ++++
 rtl/maxnum_step_counter.sv | 131 +++++++++++++
 tb/tb_maxnum_step_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnum_pkg.sv
// Shared definitions for the maxNum step counter and the blocks around it.
// Holds the counter width default, the FSM state encoding and the per-mode
// limit constants produced by the mode-to-maxNum converter.
package maxnum_pkg;

    // Width of maxNum/count; must match the converter's output width.
    localparam int unsigned MAXNUM_CNT_W = 5;

    // FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Non-zero limits emitted by the converter for its valid modes.
    localparam int unsigned MAXNUM_LIMIT_0 = 6;
    localparam int unsigned MAXNUM_LIMIT_1 = 11;
    localparam int unsigned MAXNUM_LIMIT_2 = 5;
    localparam int unsigned MAXNUM_LIMIT_3 = 16;

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler producing one count-step tick every TICK_DIV enabled cycles.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - restart the prescaler phase from 0 (wins over en)
//   en   - advance the prescaler this cycle; phase is frozen while low
//   tick - high in the enabled cycle whose edge completes a step
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // With TICK_DIV=1 the phase register stays at 0 and every enabled cycle ticks.
    assign tick = en && (presc_q == LAST);

    // Next phase: clear, wrap on tick, or count up while enabled.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/maxnum_step_counter.sv
// Prescaled up-counter from 0 to a latched maxNum limit, with run, pause,
// stop, single-shot and looping operation.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - (re)start request; accepted only when max_num != 0
//   stop            - abort to IDLE, clearing count
//   pause           - freeze counting while high in RUN
//   loop_en         - wrap to 0 at the limit instead of finishing
//   max_num         - limit, latched on an accepted start
//   count           - current count value
//   busy / done     - state decodes (RUN or HOLD / DONE)
//   wrap / err      - one-cycle pulses: loop wrap / rejected start
module maxnum_step_counter
    import maxnum_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = MAXNUM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [CNT_W-1:0] max_num,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic start_ok;
    logic start_rej;
    logic presc_clr;
    logic presc_en;
    logic tick;

    assign start_ok  = start && (max_num != '0);
    assign start_rej = start && (max_num == '0);

    // Phase restarts on every accepted start; it only advances in RUN.
    assign presc_clr = start_ok && !stop;
    assign presc_en  = (state_q == ST_RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Next-state logic; priority is stop > start > pause.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start_ok) begin
            state_d = ST_RUN;
            limit_d = max_num;
            count_d = '0;
        end else begin
            // A rejected start only flags; the current activity carries on.
            err_d = start_rej;
            case (state_q)
                ST_RUN: begin
                    // Pause takes effect next cycle; a tick on this edge still lands.
                    if (pause) begin
                        state_d = ST_HOLD;
                    end
                    if (tick) begin
                        if (count_q != limit_q) begin
                            count_d = count_q + CNT_W'(1);
                        end else if (loop_en) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign done  = (state_q == ST_DONE);
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_maxnum_step_counter.sv
// Self-checking bench for maxnum_step_counter (TICK_DIV=4, CNT_W=5).
module tb_maxnum_step_counter;
    import maxnum_pkg::*;

    localparam int unsigned TB_W = 5;

    logic            clk = 1'b0;
    logic            rst, start, stop, pause, loop_en;
    logic [TB_W-1:0] max_num;
    logic [TB_W-1:0] count;
    logic            busy, done, wrap, err;

    maxnum_step_counter #(
        .TICK_DIV (4),
        .CNT_W    (TB_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
        .max_num (max_num),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            rst, stop, start, pause, loop_en;
        logic [TB_W-1:0] max_num;
        logic [TB_W-1:0] e_count;
        logic            e_busy, e_done, e_wrap, e_err;
    } vec_t;

    typedef struct packed {
        logic [TB_W-1:0] count;
        logic            busy, done, wrap, err;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    step_id = 0;
    int    wraps = 0;
    string phase = "init";

    localparam logic [TB_W-1:0] L6  = TB_W'(MAXNUM_LIMIT_0);
    localparam logic [TB_W-1:0] L11 = TB_W'(MAXNUM_LIMIT_1);
    localparam logic [TB_W-1:0] L5  = TB_W'(MAXNUM_LIMIT_2);
    localparam logic [TB_W-1:0] L16 = TB_W'(MAXNUM_LIMIT_3);

    task automatic drive(input logic r, input logic sp, input logic st,
                         input logic pa, input logic lp, input logic [TB_W-1:0] m);
        rst = r; stop = sp; start = st; pause = pa; loop_en = lp; max_num = m;
    endtask

    task automatic push(input logic [TB_W-1:0] c, input logic b, input logic d,
                        input logic w, input logic e);
        exp_t x;
        x = '{c, b, d, w, e};
        sb_q.push_back(x);
    endtask

    // Advance one edge and compare the DUT against the oldest expectation.
    task automatic tick_check();
        exp_t e;
        exp_t a;
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s step %0d: no expected entry queued", phase, step_id);
        end else begin
            e = sb_q.pop_front();
            a = '{count, busy, done, wrap, err};
            if (a !== e) begin
                errors++;
                $display("FAIL %s step %0d: got count=%0d busy=%b done=%b wrap=%b err=%b, want count=%0d busy=%b done=%b wrap=%b err=%b",
                         phase, step_id, a.count, a.busy, a.done, a.wrap, a.err,
                         e.count, e.busy, e.done, e.wrap, e.err);
            end
        end
        step_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        int   eff;

        drive(1, 0, 0, 0, 0, '0);

        // Reset, rejection and priority vectors, one edge each.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, L6,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, L6,    5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, L6,    5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, L6,    5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, L6,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, L6,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        phase = "table";
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].stop, vecs[i].start, vecs[i].pause,
                  vecs[i].loop_en, vecs[i].max_num);
            push(vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done,
                 vecs[i].e_wrap, vecs[i].e_err);
            tick_check();
        end

        // Single-shot to 6: step every 4 cycles, DONE 28 cycles after entry.
        phase = "single";
        drive(0, 0, 1, 0, 0, L6);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 30; k++) begin
            drive(0, 0, 0, 0, 0, L6);
            if (k < 28) push(TB_W'(k / 4), 1, 0, 0, 0);
            else        push(L6, 0, 1, 0, 0);
            tick_check();
        end

        // Rejected start in DONE stays in DONE.
        phase = "reject_done";
        drive(0, 0, 1, 0, 0, 5'd0);
        push(L6, 0, 1, 0, 1);
        tick_check();
        drive(0, 0, 0, 0, 0, 5'd0);
        push(L6, 0, 1, 0, 0);
        tick_check();

        // Looping to 5: wrap pulse every 24 cycles, three wraps.
        phase = "loop";
        drive(0, 0, 1, 0, 1, L5);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 74; k++) begin
            drive(0, 0, 0, 0, 1, L5);
            push(TB_W'((k / 4) % 6), 1, 0, (k % 24) == 0, 0);
            tick_check();
            if (wrap) wraps++;
        end
        checks++;
        if (wraps != 3) begin
            errors++;
            $display("FAIL loop_wraps: got %0d wraps, want 3", wraps);
        end
        drive(0, 1, 0, 0, 1, L5);
        push(0, 0, 0, 0, 0);
        tick_check();

        // Pause 10 cycles starting at prescaler=2, count=3.
        phase = "pause";
        drive(0, 0, 1, 0, 0, L11);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 0, (k >= 15 && k <= 24), 0, L11);
            if (k <= 15)      eff = k;
            else if (k <= 25) eff = 15;
            else              eff = k - 10;
            if (eff >= 48) push(L11, 0, 1, 0, 0);
            else           push(TB_W'(eff / 4), 1, 0, 0, 0);
            tick_check();
        end

        // Latched limit, rejected restart, restart with new limit, stop.
        phase = "latch";
        drive(0, 0, 1, 0, 0, L16);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 45; k++) begin
            drive(0, 0, (k == 42), 0, 0, (k <= 36) ? L16 : ((k == 42) ? 5'd0 : L5));
            push(TB_W'(k / 4), 1, 0, 0, (k == 42));
            tick_check();
        end
        phase = "restart";
        drive(0, 0, 1, 0, 0, L5);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 26; k++) begin
            drive(0, 0, 0, 0, 0, L5);
            if (k < 24) push(TB_W'(k / 4), 1, 0, 0, 0);
            else        push(L5, 0, 1, 0, 0);
            tick_check();
        end
        phase = "stop";
        drive(0, 0, 1, 0, 0, L5);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 13; k++) begin
            drive(0, 0, 0, 0, 0, L5);
            push(TB_W'(k / 4), 1, 0, 0, 0);
            tick_check();
        end
        drive(0, 1, 0, 0, 0, L5);
        push(0, 0, 0, 0, 0);
        tick_check();

        // Reset mid-run at count=7, then start with stop held.
        phase = "reset_mid";
        drive(0, 0, 1, 0, 0, L16);
        push(0, 1, 0, 0, 0);
        tick_check();
        for (int k = 1; k <= 29; k++) begin
            drive(0, 0, 0, 0, 0, L16);
            push(TB_W'(k / 4), 1, 0, 0, 0);
            tick_check();
        end
        drive(1, 0, 1, 0, 0, L16);
        push(0, 0, 0, 0, 0);
        tick_check();
        drive(0, 1, 1, 0, 0, L16);
        push(0, 0, 0, 0, 0);
        tick_check();
        drive(0, 0, 0, 0, 0, L16);
        push(0, 0, 0, 0, 0);
        tick_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
